// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the IF/MEM bus arbiter
// Contents: bus width constants, arbiter FSM state encoding, default timeout,
// and a helper that identifies the states in which a bus cycle is open.
package bus_arbiter_pkg;

  // Widths of the existing memory bus.
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_SEL_W  = 4;

  // Cycles to wait for mem_ack_i before aborting; 0 disables the abort.
  localparam int ArbTimeoutDefault = 255;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusD = 2'd1,
    ArbBusI = 2'd2,
    ArbResp = 2'd3
  } arb_state_e;

  function automatic logic is_bus_state(arb_state_e s);
    return (s == ArbBusD) || (s == ArbBusI);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - fetch, data and memory-port signal bundle of the bus arbiter
// slave  : arbiter side (takes requests and memory responses, drives grants/bus)
// master : environment side (requesters plus memory)
// Fetch : if_req_i, if_addr_i, flush_i -> if_rdata_o, if_ack_o, if_err_o, stallreq_if_o
// Data  : d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i -> d_rdata_o, d_ack_o, d_err_o, stallreq_mem_o
// Memory: mem_cyc_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o <- mem_rdata_i, mem_ack_i
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) ();

  logic                 if_req_i;
  logic [ADDR_W-1:0]    if_addr_i;
  logic [DATA_W-1:0]    if_rdata_o;
  logic                 if_ack_o;
  logic                 if_err_o;
  logic                 flush_i;

  logic                 d_req_i;
  logic                 d_we_i;
  logic [ADDR_W-1:0]    d_addr_i;
  logic [DATA_W-1:0]    d_wdata_i;
  logic [BUS_SEL_W-1:0] d_sel_i;
  logic [DATA_W-1:0]    d_rdata_o;
  logic                 d_ack_o;
  logic                 d_err_o;

  logic                 mem_cyc_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [DATA_W-1:0]    mem_wdata_o;
  logic [BUS_SEL_W-1:0] mem_sel_o;
  logic [DATA_W-1:0]    mem_rdata_i;
  logic                 mem_ack_i;

  logic                 stallreq_if_o;
  logic                 stallreq_mem_o;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
    input  mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_ack_o, if_err_o,
    output d_rdata_o, d_ack_o, d_err_o,
    output mem_cyc_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    output stallreq_if_o, stallreq_mem_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
    output mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_ack_o, if_err_o,
    input  d_rdata_o, d_ack_o, d_err_o,
    input  mem_cyc_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    input  stallreq_if_o, stallreq_mem_o
  );

endinterface

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - loadable down-counter that flags a hung bus cycle
// clk, rst   : clock, synchronous active-high reset
// clr_i      : reload with TIMEOUT-1 (asserted on grant)
// en_i       : count down one step (bus cycle open, no mem_ack_i)
// expired_o  : count reached zero; held low when TIMEOUT is 0
module bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count_q;

  // Loading TIMEOUT-1 makes zero coincide with the last allowed wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= LOAD;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (count_q == '0);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one memory port between instruction fetch and data access
// clk, rst : clock, synchronous active-high reset
// bus      : bus_arbiter_if.slave carrying the fetch, data and memory ports
// One transaction at a time: IDLE -> BUS_D/BUS_I -> RESP -> IDLE.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = ArbTimeoutDefault
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);

  arb_state_e           state_q;
  logic                 flushed_q;
  logic                 mem_cyc_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [BUS_SEL_W-1:0] mem_sel_q;
  logic                 if_ack_q;
  logic                 if_err_q;
  logic [DATA_W-1:0]    if_rdata_q;
  logic                 d_ack_q;
  logic                 d_err_q;
  logic [DATA_W-1:0]    d_rdata_q;

  logic grant_d;
  logic grant_i;
  logic fetch_dead;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  // Data always wins: it belongs to the older instruction in the pipe.
  assign grant_d    = (state_q == ArbIdle) && bus.d_req_i;
  assign grant_i    = (state_q == ArbIdle) && !bus.d_req_i && bus.if_req_i && !bus.flush_i;
  // A flush seen at any point of the fetch, including its final cycle, kills the result.
  assign fetch_dead = flushed_q || bus.flush_i;

  assign tmr_clr = grant_d || grant_i;
  assign tmr_en  = is_bus_state(state_q) && !bus.mem_ack_i;

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      flushed_q   <= 1'b0;
      mem_cyc_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      // Completion strobes are single-cycle: only the entry into RESP sets them.
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;

      case (state_q)
        ArbIdle: begin
          if (grant_d) begin
            state_q     <= ArbBusD;
            mem_cyc_q   <= 1'b1;
            mem_we_q    <= bus.d_we_i;
            mem_addr_q  <= bus.d_addr_i;
            mem_wdata_q <= bus.d_wdata_i;
            mem_sel_q   <= bus.d_sel_i;
          end else if (grant_i) begin
            state_q     <= ArbBusI;
            mem_cyc_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= '0;
            mem_sel_q   <= '1;
          end
        end

        ArbBusD: begin
          if (bus.mem_ack_i) begin
            state_q   <= ArbResp;
            mem_cyc_q <= 1'b0;
            d_ack_q   <= 1'b1;
            if (!mem_we_q) begin
              d_rdata_q <= bus.mem_rdata_i;
            end
          end else if (tmr_expired) begin
            state_q   <= ArbResp;
            mem_cyc_q <= 1'b0;
            d_err_q   <= 1'b1;
            d_rdata_q <= '0;
          end
        end

        ArbBusI: begin
          flushed_q <= fetch_dead;
          if (bus.mem_ack_i) begin
            state_q   <= ArbResp;
            mem_cyc_q <= 1'b0;
            if (!fetch_dead) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata_i;
            end
          end else if (tmr_expired) begin
            state_q   <= ArbResp;
            mem_cyc_q <= 1'b0;
            if (!fetch_dead) begin
              if_err_q   <= 1'b1;
              if_rdata_q <= '0;
            end
          end
        end

        ArbResp: begin
          // Requests are deliberately not sampled here so the requester
          // has one cycle to drop or change req after its ack.
          state_q   <= ArbIdle;
          flushed_q <= 1'b0;
        end

        default: begin
          state_q <= ArbIdle;
        end
      endcase
    end
  end

  assign bus.mem_cyc_o   = mem_cyc_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_sel_o   = mem_sel_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_err_o    = if_err_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_ack_o     = d_ack_q;
  assign bus.d_err_o     = d_err_q;
  assign bus.d_rdata_o   = d_rdata_q;

  assign bus.stallreq_if_o  = bus.if_req_i && !if_ack_q;
  assign bus.stallreq_mem_o = bus.d_req_i && !(d_ack_q || d_err_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed-vector self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   mem_lat;   // >=0: ack after that many cycles of mem_cyc_o; -1: never; -2: ack every cycle

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h3C01_0001;
      32'h0000_0014: return 32'h8C22_0004;
      32'h0000_0018: return 32'hAC23_0008;
      32'h0000_0020: return 32'h2442_0001;
      32'h0000_0030: return 32'h0BAD_0030;
      32'h0000_0040: return 32'h1000_FFFF;
      32'h0000_0104: return 32'hCAFE_F00D;
      32'h0000_0300: return 32'h1234_5678;
      default:       return 32'hA5A5_A5A5;
    endcase
  endfunction

  // Memory model: only this process drives mem_ack_i / mem_rdata_i.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_lat == -2) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h5555_5555;
      end else if (bus.mem_cyc_o) begin
        if (mem_lat >= 0 && cnt == mem_lat) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_word(bus.mem_addr_o);
        end else begin
          bus.mem_ack_i   = 1'b0;
          bus.mem_rdata_i = '0;
        end
        cnt++;
      end else begin
        cnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return bus.if_ack_o;
      1:       return bus.d_ack_o;
      default: return bus.d_err_o;
    endcase
  endfunction

  // Step negedges until the selected strobe is seen or the budget runs out.
  task automatic wait_for(input string tag, input int which, input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_of(which) && n < maxc);
    chk(tag, {31'd0, sig_of(which)}, 32'd1);
  endtask

  task automatic idle_inputs();
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.flush_i   = 1'b0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    bus.d_sel_i   = '0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    mem_lat = 2;
    rst     = 1'b1;
    idle_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc",    {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("rst_if_ack", {31'd0, bus.if_ack_o}, 32'd0);
    chk("rst_d_ack",  {31'd0, bus.d_ack_o}, 32'd0);
    chk("rst_if_rd",  bus.if_rdata_o, 32'd0);
    chk("rst_d_rd",   bus.d_rdata_o, 32'd0);
    chk("rst_sel",    {28'd0, bus.mem_sel_o}, 32'd0);
    rst = 1'b0;

    // Single fetch, memory acks on the third bus cycle
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    @(negedge clk);
    chk("f1_cyc",   {31'd0, bus.mem_cyc_o}, 32'd1);
    chk("f1_addr",  bus.mem_addr_o, 32'h10);
    chk("f1_sel",   {28'd0, bus.mem_sel_o}, 32'hF);
    chk("f1_we",    {31'd0, bus.mem_we_o}, 32'd0);
    chk("f1_stall", {31'd0, bus.stallreq_if_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("f1_noack", {31'd0, bus.if_ack_o}, 32'd0);
    chk("f1_cyc2",  {31'd0, bus.mem_cyc_o}, 32'd1);
    @(negedge clk);
    chk("f1_ack",    {31'd0, bus.if_ack_o}, 32'd1);
    chk("f1_rdata",  bus.if_rdata_o, 32'h3C01_0001);
    chk("f1_unstal", {31'd0, bus.stallreq_if_o}, 32'd0);
    chk("f1_cyc0",   {31'd0, bus.mem_cyc_o}, 32'd0);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    chk("f1_pulse", {31'd0, bus.if_ack_o}, 32'd0);

    // Simultaneous requests: data write first, then the fetch
    mem_lat       = 0;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h100;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    bus.d_sel_i   = 4'b0011;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h20;
    @(negedge clk);
    chk("s_we",    {31'd0, bus.mem_we_o}, 32'd1);
    chk("s_addr",  bus.mem_addr_o, 32'h100);
    chk("s_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    chk("s_sel",   {28'd0, bus.mem_sel_o}, 32'h3);
    chk("s_stif",  {31'd0, bus.stallreq_if_o}, 32'd1);
    @(negedge clk);
    chk("s_dack",  {31'd0, bus.d_ack_o}, 32'd1);
    chk("s_stmem", {31'd0, bus.stallreq_mem_o}, 32'd0);
    chk("s_stif2", {31'd0, bus.stallreq_if_o}, 32'd1);
    bus.d_req_i = 1'b0;
    @(negedge clk);
    chk("s_idle",  {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("s_stif3", {31'd0, bus.stallreq_if_o}, 32'd1);
    @(negedge clk);
    chk("s_fcyc",  {31'd0, bus.mem_cyc_o}, 32'd1);
    chk("s_faddr", bus.mem_addr_o, 32'h20);
    chk("s_fsel",  {28'd0, bus.mem_sel_o}, 32'hF);
    @(negedge clk);
    chk("s_fack",  {31'd0, bus.if_ack_o}, 32'd1);
    chk("s_frd",   bus.if_rdata_o, 32'h2442_0001);
    chk("s_drd",   bus.d_rdata_o, 32'd0);
    bus.if_req_i = 1'b0;

    // Data read with one wait cycle
    @(negedge clk);
    mem_lat      = 1;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h104;
    bus.d_sel_i  = 4'hF;
    @(negedge clk);
    chk("r_stmem", {31'd0, bus.stallreq_mem_o}, 32'd1);
    wait_for("r_dack", 1, 6);
    chk("r_drd", bus.d_rdata_o, 32'hCAFE_F00D);
    chk("r_ifrd", bus.if_rdata_o, 32'h2442_0001);
    bus.d_req_i = 1'b0;

    // Flush: blocks grant in IDLE, then kills an in-flight fetch
    @(negedge clk);
    mem_lat       = 2;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h30;
    bus.flush_i   = 1'b1;
    @(negedge clk);
    chk("fl_block", {31'd0, bus.mem_cyc_o}, 32'd0);
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("fl_cyc", {31'd0, bus.mem_cyc_o}, 32'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_noack", {31'd0, bus.if_ack_o}, 32'd0);
    chk("fl_noerr", {31'd0, bus.if_err_o}, 32'd0);
    chk("fl_done",  {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("fl_rd",    bus.if_rdata_o, 32'h2442_0001);
    bus.if_addr_i = 32'h40;
    @(negedge clk);
    chk("fl_noack2", {31'd0, bus.if_ack_o}, 32'd0);
    wait_for("fl_ack40", 0, 10);
    chk("fl_rd40", bus.if_rdata_o, 32'h1000_FFFF);
    bus.if_req_i = 1'b0;

    // Timeout on a data read (TIMEOUT = 4)
    @(negedge clk);
    mem_lat      = -1;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h200;
    bus.d_sel_i  = 4'hF;
    repeat (4) @(negedge clk);
    chk("to_cyc4", {31'd0, bus.mem_cyc_o}, 32'd1);
    chk("to_noerr", {31'd0, bus.d_err_o}, 32'd0);
    @(negedge clk);
    chk("to_cyc0", {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("to_err",  {31'd0, bus.d_err_o}, 32'd1);
    chk("to_noack", {31'd0, bus.d_ack_o}, 32'd0);
    chk("to_rd0",  bus.d_rdata_o, 32'd0);
    bus.d_req_i = 1'b0;
    @(negedge clk);
    chk("to_pulse", {31'd0, bus.d_err_o}, 32'd0);
    mem_lat = -2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_late_ack", {31'd0, bus.d_ack_o}, 32'd0);
      chk("to_late_cyc", {31'd0, bus.mem_cyc_o}, 32'd0);
    end
    mem_lat = -1;

    // Reset while a data read is outstanding
    @(negedge clk);
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h300;
    @(negedge clk);
    chk("rm_cyc", {31'd0, bus.mem_cyc_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_cyc0", {31'd0, bus.mem_cyc_o}, 32'd0);
    chk("rm_ack",  {31'd0, bus.d_ack_o}, 32'd0);
    chk("rm_err",  {31'd0, bus.d_err_o}, 32'd0);
    rst     = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    chk("rm_regrant", {31'd0, bus.mem_cyc_o}, 32'd1);
    wait_for("rm_dack", 1, 6);
    chk("rm_rd", bus.d_rdata_o, 32'h1234_5678);
    bus.d_req_i = 1'b0;

    // Back-to-back fetches with zero-wait memory: one ack every 3 cycles
    @(negedge clk);
    mem_lat       = 0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("bb_ack0", {31'd0, bus.if_ack_o}, 32'd1);
    chk("bb_rd0",  bus.if_rdata_o, 32'h3C01_0001);
    for (int k = 1; k < 3; k++) begin
      bus.if_addr_i = (k == 1) ? 32'h14 : 32'h18;
      @(negedge clk);
      chk("bb_gap1", {31'd0, bus.if_ack_o}, 32'd0);
      @(negedge clk);
      chk("bb_gap2", {31'd0, bus.if_ack_o}, 32'd0);
      @(negedge clk);
      chk("bb_ack", {31'd0, bus.if_ack_o}, 32'd1);
      chk("bb_rd",  bus.if_rdata_o, (k == 1) ? 32'h8C22_0004 : 32'hAC23_0008);
    end
    bus.if_req_i = 1'b0;
    @(negedge clk);
    chk("bb_end", {31'd0, bus.if_ack_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
